// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC request scheduler.
package cordic_pkg;

  // Angles are signed Q16.16 degrees.
  localparam int FRAC      = 16;
  localparam int ANGLE_90  = 90 << FRAC;   // 5898240
  localparam int ANGLE_180 = 180 << FRAC;  // 11796480

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] ptr_q, ptr_d;

  // Find the first active request at or after the pointer, wrapping around.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!grant_any && req[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
    grant = grant_any ? (NREQ'(1) << grant_idx) : '0;
  end

  // Next pointer: one past the accepted winner, modulo NREQ.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && grant_any) begin
      if (grant_idx == IDW'(NREQ - 1)) ptr_d = '0;
      else                             ptr_d = grant_idx + IDW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one CORDIC rotation core between NREQ angle requesters:
// arbitration, quadrant folding, start pulse, result capture with sign
// correction, buffered response with back-pressure, and a core watchdog.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_angle,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_cos,
  output logic [WIDTH-1:0]      rsp_sin,
  output logic                  rsp_err,
  output logic                  core_start,
  output logic [WIDTH-1:0]      core_angle,
  input  logic [WIDTH-1:0]      core_cos,
  input  logic [WIDTH-1:0]      core_sin,
  input  logic                  core_done
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  localparam logic signed [WIDTH-1:0] POS_90  = WIDTH'(ANGLE_90);
  localparam logic signed [WIDTH-1:0] NEG_90  = WIDTH'(-ANGLE_90);
  localparam logic signed [WIDTH-1:0] POS_180 = WIDTH'(ANGLE_180);
  localparam logic signed [WIDTH-1:0] NEG_180 = WIDTH'(-ANGLE_180);

  sched_state_e      state_q, state_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_cos_q, rsp_cos_d;
  logic [WIDTH-1:0]  rsp_sin_q, rsp_sin_d;
  logic              rsp_err_q, rsp_err_d;
  logic              core_start_q, core_start_d;
  logic [WIDTH-1:0]  core_angle_q, core_angle_d;
  logic              neg_q, neg_d;
  logic [WDW-1:0]    wd_q, wd_d;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic              grant_any;
  logic              accept;

  logic signed [WIDTH-1:0] win_angle;
  logic signed [WIDTH-1:0] folded;
  logic                    fold_neg;
  logic                    in_range;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Select the winning requester's angle.
  always_comb begin
    win_angle = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) win_angle = req_angle[i*WIDTH +: WIDTH];
    end
  end

  // Range check and fold into the core's +/-90 degree window; the
  // half-turn shift flips the sign of both cos and sin.
  always_comb begin
    in_range = (win_angle >= NEG_180) && (win_angle < POS_180);
    folded   = win_angle;
    fold_neg = 1'b0;
    if (win_angle > POS_90) begin
      folded   = win_angle - POS_180;
      fold_neg = 1'b1;
    end else if (win_angle < NEG_90) begin
      folded   = win_angle + POS_180;
      fold_neg = 1'b1;
    end
  end

  // Grants are only visible while idle.
  always_comb begin
    req_ready = (state_q == S_IDLE) ? grant : '0;
  end

  // Scheduler next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_cos_d    = rsp_cos_q;
    rsp_sin_d    = rsp_sin_q;
    rsp_err_d    = rsp_err_q;
    core_start_d = 1'b0;
    core_angle_d = core_angle_q;
    neg_d        = neg_q;
    wd_d         = wd_q;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          accept   = 1'b1;
          rsp_id_d = grant_idx;
          if (!in_range) begin
            rsp_err_d   = 1'b1;
            rsp_cos_d   = '0;
            rsp_sin_d   = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            core_angle_d = folded;
            neg_d        = fold_neg;
            core_start_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (core_done) begin
          rsp_cos_d   = neg_q ? (~core_cos + WIDTH'(1)) : core_cos;
          rsp_sin_d   = neg_q ? (~core_sin + WIDTH'(1)) : core_sin;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          rsp_cos_d   = '0;
          rsp_sin_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_cos_q    <= '0;
      rsp_sin_q    <= '0;
      rsp_err_q    <= 1'b0;
      core_start_q <= 1'b0;
      core_angle_q <= '0;
      neg_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_cos_q    <= rsp_cos_d;
      rsp_sin_q    <= rsp_sin_d;
      rsp_err_q    <= rsp_err_d;
      core_start_q <= core_start_d;
      core_angle_q <= core_angle_d;
      neg_q        <= neg_d;
      wd_q         <= wd_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_cos    = rsp_cos_q;
  assign rsp_sin    = rsp_sin_q;
  assign rsp_err    = rsp_err_q;
  assign core_start = core_start_q;
  assign core_angle = core_angle_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched with a behavioural core model that
// returns tabulated Q16.16 cos/sin for the folded angles used here.
module tb_cordic_sched;

  localparam int W = 32;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_angle;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W-1:0]    rsp_cos;
  logic [W-1:0]    rsp_sin;
  logic            rsp_err;
  logic            core_start;
  logic [W-1:0]    core_angle;
  logic [W-1:0]    core_cos;
  logic [W-1:0]    core_sin;
  logic            core_done;

  int checks = 0;
  int errors = 0;

  cordic_sched #(.WIDTH(W), .NREQ(N), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_angle  (req_angle),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_cos    (rsp_cos),
    .rsp_sin    (rsp_sin),
    .rsp_err    (rsp_err),
    .core_start (core_start),
    .core_angle (core_angle),
    .core_cos   (core_cos),
    .core_sin   (core_sin),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;

  // Core model: done pulses stub_lat+1 cycles after the start cycle.
  int          stub_lat = 3;
  bit          stub_en  = 1'b1;
  int          stub_cnt = 0;
  logic [W-1:0] stub_ang = '0;
  int          start_cnt = 0;
  int          multi_ready = 0;

  task automatic lut(input logic [W-1:0] a, output logic [W-1:0] c, output logic [W-1:0] s);
    case (a)
      32'd0:              begin c = 32'd65536; s = 32'd0;          end
      32'd1966080:        begin c = 32'd56756; s = 32'd32768;      end
      32'(-1966080):      begin c = 32'd56756; s = 32'(-32768);    end
      32'd3932160:        begin c = 32'd32768; s = 32'd56756;      end
      32'(-3932160):      begin c = 32'd32768; s = 32'(-56756);    end
      32'd5898240:        begin c = 32'd0;     s = 32'd65536;      end
      32'(-5898240):      begin c = 32'd0;     s = 32'(-65536);    end
      default:            begin c = 32'd12345; s = 32'd12345;      end
    endcase
  endtask

  always @(posedge clk) begin
    logic [W-1:0] c, s;
    core_done <= 1'b0;
    if (core_start) begin
      stub_cnt <= stub_lat;
      stub_ang <= core_angle;
      start_cnt <= start_cnt + 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && stub_en) begin
        lut(stub_ang, c, s);
        core_done <= 1'b1;
        core_cos  <= c;
        core_sin  <= s;
      end
    end
  end

  always @(negedge clk) begin
    if (!$onehot0(req_ready)) multi_ready <= multi_ready + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Offer a single request and confirm it is granted; returns at the
  // negedge of the cycle after acceptance.
  task automatic present(input int r, input logic [W-1:0] a);
    @(negedge clk);
    req_angle[r*W +: W] = a;
    req_valid = N'(1) << r;
    #1;
    check("req_ready", 32'(req_ready), 32'(N'(1) << r));
    @(negedge clk);
    req_valid = '0;
  endtask

  // Wait (bounded) for rsp_valid; reports cycles waited and whether
  // core_done was high on the preceding cycle.
  task automatic wait_rsp(output int n, output bit done_prev);
    bit ok;
    bit prev;
    ok = 0; prev = 0; n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid) begin ok = 1; break; end
      prev = core_done;
    end
    done_prev = prev;
    check("rsp_arrives", 32'(ok), 32'd1);
  endtask

  task automatic job_ok(input int r, input logic [W-1:0] a, input logic [W-1:0] exp_core,
                        input logic [W-1:0] exp_cos, input logic [W-1:0] exp_sin);
    int s0, n;
    bit dp;
    s0 = start_cnt;
    present(r, a);
    check("core_start", 32'(core_start), 32'd1);
    check("core_angle", core_angle, exp_core);
    wait_rsp(n, dp);
    check("latency", 32'(n), 32'(stub_lat + 2));
    check("done_then_rsp", 32'(dp), 32'd1);
    check("start_pulses", 32'(start_cnt - s0), 32'd1);
    check("rsp_id", 32'(rsp_id), 32'(r));
    check("rsp_cos", rsp_cos, exp_cos);
    check("rsp_sin", rsp_sin, exp_sin);
    check("rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic job_err(input int r, input logic [W-1:0] a);
    int s0;
    s0 = start_cnt;
    present(r, a);
    check("err_valid", 32'(rsp_valid), 32'd1);
    check("err_flag", 32'(rsp_err), 32'd1);
    check("err_cos", rsp_cos, 32'd0);
    check("err_sin", rsp_sin, 32'd0);
    check("err_id", 32'(rsp_id), 32'(r));
    @(negedge clk);
    check("err_no_start", 32'(start_cnt - s0), 32'd0);
    check("err_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_cos"}, rsp_cos, 32'd0);
    check({tag, "_rsp_sin"}, rsp_sin, 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_core_start"}, 32'(core_start), 32'd0);
    check({tag, "_core_angle"}, core_angle, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit dp;
    bit seen;

    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = '0; req_angle = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all four requesters continuously valid from pointer 0.
    req_angle = '0;
    req_valid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      bit got;
      got = 0;
      for (int i = 0; i < 50; i++) begin
        if (req_ready != '0) begin got = 1; break; end
        @(negedge clk);
      end
      check("rr_grant_seen", 32'(got), 32'd1);
      check("rr_grant", 32'(req_ready), 32'(N'(1) << (k % 4)));
      wait_rsp(n, dp);
      if (k == 4) req_valid = '0;
      check("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
      check("rr_rsp_cos", rsp_cos, 32'd65536);
    end
    @(negedge clk);
    check("rr_onehot", 32'(multi_ready), 32'd0);

    // Plain and folded angles, including the unfolded +/-90 boundaries.
    job_ok(0, 32'd1966080, 32'd1966080, 32'd56756, 32'd32768);
    job_ok(1, 32'd9830400, 32'(-1966080), 32'(-56756), 32'd32768);
    job_ok(3, 32'(-7864320), 32'd3932160, 32'(-32768), 32'(-56756));
    job_ok(2, 32'd5898240, 32'd5898240, 32'd0, 32'd65536);
    job_ok(0, 32'(-5898240), 32'(-5898240), 32'd0, 32'(-65536));

    // Range boundaries: +180 rejected, -180 legal and folded to 0.
    job_err(2, 32'd11796480);
    job_err(1, 32'h7FFF_FFFF);
    job_ok(2, 32'(-11796480), 32'd0, 32'(-65536), 32'd0);

    // Back-pressure: response held for 10 cycles, no grants meanwhile.
    rsp_ready = 1'b0;
    present(0, 32'd1966080);
    wait_rsp(n, dp);
    req_valid = 4'b0010;
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_cos", rsp_cos, 32'd56756);
      check("bp_sin", rsp_sin, 32'd32768);
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_idle", 32'(req_ready), 32'b0010);
    req_valid = '0;

    // Watchdog: core never answers.
    stub_en = 1'b0;
    present(1, 32'd1966080);
    wait_rsp(n, dp);
    check("wd_cycles", 32'(n), 32'd65);
    check("wd_err", 32'(rsp_err), 32'd1);
    check("wd_cos", rsp_cos, 32'd0);
    check("wd_sin", rsp_sin, 32'd0);
    check("wd_id", 32'(rsp_id), 32'd1);
    @(negedge clk);
    check("wd_drop", 32'(rsp_valid), 32'd0);
    stub_en = 1'b1;

    // Reset during WAIT: job abandoned, late core_done ignored.
    stub_lat = 20;
    present(3, 32'd1966080);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    stub_lat = 3;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("midreset_no_rsp", 32'(seen), 32'd0);

    // Pointer back at 0 after reset.
    req_angle = '0;
    req_valid = '1;
    #1;
    check("ptr_reset_grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(n, dp);
    check("ptr_reset_id", 32'(rsp_id), 32'd0);
    check("ptr_reset_cos", rsp_cos, 32'd65536);
    @(negedge clk);

    job_ok(2, 32'd7864320, 32'(-3932160), 32'(-32768), 32'd56756);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
